// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering one MEM-stage request at a time.
// A fixed LATENCY separates acceptance from the response; stall covers the whole op.
module data_mem_responder #(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic          write_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          req_ready_q;
    logic          resp_valid_q;
    logic          resp_err_q;
    logic          stall_q;
    logic [31:0]   rdata_q;

    logic [31:0]   mem [DEPTH];

    logic          in_range;
    logic          commit;
    logic [AW-1:0] idx;

    // Full 32-bit compare so large addresses never alias into the array.
    assign in_range = addr_q < 32'(DEPTH);
    assign idx      = addr_q[AW-1:0];
    assign commit   = (state_q == WAIT) && (cnt_q == 4'd0);

    always_ff @(posedge clk) begin
        if (commit && write_q && in_range) begin
            mem[idx] <= wdata_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= 32'd0;
            stall_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q     <= req_write;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        cnt_q       <= 4'(LATENCY - 1);
                        state_q     <= WAIT;
                        req_ready_q <= 1'b0;
                        stall_q     <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= ~in_range;
                        rdata_q      <= (in_range && !write_q) ? mem[idx] : 32'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        rdata_q      <= 32'd0;
                        req_ready_q  <= 1'b1;
                        stall_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = resp_err_q;
    assign stall      = stall_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against an array-based memory model.
// Extra LATENCY=1 and LATENCY=15 instances cover the timing sweep.
module tb_data_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;

    logic        v1, rr1, r1_ready, r1_valid, r1_err, r1_stall;
    logic [31:0] r1_rdata;
    logic        v15, rr15, r15_ready, r15_valid, r15_err, r15_stall;
    logic [31:0] r15_rdata;

    logic [31:0] model [512];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(512), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .stall(stall)
    );

    data_mem_responder #(.DEPTH(512), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(v1), .req_ready(r1_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(r1_valid), .resp_ready(rr1),
        .resp_rdata(r1_rdata), .resp_err(r1_err), .stall(r1_stall)
    );

    data_mem_responder #(.DEPTH(512), .LATENCY(15)) dut_l15 (
        .clk(clk), .rst(rst),
        .req_valid(v15), .req_ready(r15_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(r15_valid), .resp_ready(rr15),
        .resp_rdata(r15_rdata), .resp_err(r15_err), .stall(r15_stall)
    );

    // One complete transaction on the main instance, checked against the model.
    task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input int hold, input bit scr);
        logic [31:0] er;
        logic        ee;
        int          n;
        ee = (a >= 32'd512);
        er = (w || ee) ? 32'd0 : model[a[8:0]];
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        resp_ready = 1'b0;
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL ready_idle got=%b exp=1", req_ready);
        end
        @(posedge clk); #1;
        if (scr) begin
            req_write = ~w; req_addr = $urandom; req_wdata = $urandom;
        end else begin
            req_valid = 1'b0;
        end
        n = 0;
        while (resp_valid !== 1'b1 && n < 40) begin
            total++;
            if (stall !== 1'b1 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL busy stall=%b ready=%b exp stall=1 ready=0", stall, req_ready);
            end
            if (scr) begin
                req_addr = $urandom; req_wdata = $urandom;
            end
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n != LAT) begin
            bad++; $display("FAIL latency got=%0d exp=%0d", n, LAT);
        end
        if (w && !ee) model[a[8:0]] = d;
        total++;
        if (resp_rdata !== er) begin
            bad++; $display("FAIL rdata addr=%h got=%h exp=%h", a, resp_rdata, er);
        end
        total++;
        if (resp_err !== ee) begin
            bad++; $display("FAIL err addr=%h got=%b exp=%b", a, resp_err, ee);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            total++;
            if (resp_valid !== 1'b1 || resp_rdata !== er ||
                resp_err !== ee || stall !== 1'b1) begin
                bad++;
                $display("FAIL hold v=%b d=%h e=%b s=%b exp v=1 d=%h e=%b s=1",
                         resp_valid, resp_rdata, resp_err, stall, er, ee);
            end
        end
        @(negedge clk);
        resp_ready = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        total++;
        if ({resp_valid, req_ready, stall, resp_err} !== 4'b0100 || resp_rdata !== 32'd0) begin
            bad++;
            $display("FAIL release v=%b r=%b s=%b e=%b d=%h exp 0 1 0 0 0",
                     resp_valid, req_ready, stall, resp_err, resp_rdata);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0; v1 = 1'b0; rr1 = 1'b0; v15 = 1'b0; rr15 = 1'b0;
        #3;
        total++;
        if ({req_ready, resp_valid, resp_err, stall} !== 4'b1000 || resp_rdata !== 32'd0) begin
            bad++;
            $display("FAIL reset r=%b v=%b e=%b s=%b d=%h exp 1 0 0 0 0",
                     req_ready, resp_valid, resp_err, stall, resp_rdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_prefill;
        for (int i = 0; i < 16; i++) txn(1'b1, 32'(i), $urandom, 0, 1'b0);
        for (int i = 500; i < 512; i++) txn(1'b1, 32'(i), $urandom, 0, 1'b0);
    endtask

    task automatic test_store_load;
        txn(1'b1, 32'd5, 32'hDEADBEEF, 0, 1'b0);
        txn(1'b0, 32'd5, 32'd0, 0, 1'b0);
        total++;
        if (model[5] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL model5 got=%h exp=deadbeef", model[5]);
        end
    endtask

    task automatic test_backpressure;
        txn(1'b0, 32'd7, 32'd0, 4, 1'b0);
    endtask

    task automatic test_out_of_range;
        txn(1'b1, 32'd512, 32'd1, 0, 1'b0);
        txn(1'b0, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
        txn(1'b1, 32'h8000_0005, 32'd2, 0, 1'b0);
        txn(1'b0, 32'd0, 32'd0, 0, 1'b0);
        txn(1'b0, 32'd5, 32'd0, 0, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        total++;
        if ({req_ready, resp_valid, resp_err, stall} !== 4'b1000 || resp_rdata !== 32'd0) begin
            bad++;
            $display("FAIL %s r=%b v=%b e=%b s=%b d=%h exp 1 0 0 0 0",
                     tag, req_ready, resp_valid, resp_err, stall, resp_rdata);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd9; req_wdata = 32'h1234;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk_reset_outputs("rst_wait");
        @(negedge clk);
        rst = 1'b0;
        txn(1'b0, 32'd9, 32'd0, 0, 1'b0);
        d = $urandom;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd11; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        total++;
        if (resp_valid !== 1'b1) begin
            bad++; $display("FAIL resp_before_rst got=%b exp=1", resp_valid);
        end
        model[11] = d;
        #2 rst = 1'b1;
        #1 chk_reset_outputs("rst_resp");
        @(negedge clk);
        rst = 1'b0;
        txn(1'b0, 32'd11, 32'd0, 0, 1'b0);
    endtask

    task automatic test_ignored_inputs;
        txn(1'b1, 32'd3, 32'hA5A5_0003, 2, 1'b1);
        txn(1'b0, 32'd3, 32'd0, 1, 1'b1);
        txn(1'b0, 32'd510, 32'd0, 0, 1'b1);
    endtask

    task automatic test_random;
        logic [31:0] a;
        int k;
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 9);
            if (k < 6) a = 32'($urandom_range(0, 15));
            else if (k < 8) a = 32'($urandom_range(500, 511));
            else if (k < 9) a = 32'($urandom_range(512, 520));
            else a = $urandom | 32'h0001_0000;
            txn(1'($urandom_range(0, 1)), a, $urandom,
                $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
    endtask

    // Back-to-back requests with resp_ready tied high on the sweep instances.
    task automatic test_back_to_back;
        int acc1[$], rsp1[$], acc15[$], rsp15[$];
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'd3; req_wdata = $urandom;
        rr1 = 1'b1; rr15 = 1'b1; v1 = 1'b1; v15 = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (c > 0) @(negedge clk);
            if (r1_ready) acc1.push_back(c);
            if (r1_valid) rsp1.push_back(c - 1);
            if (r15_ready) acc15.push_back(c);
            if (r15_valid) rsp15.push_back(c - 1);
        end
        v1 = 1'b0; v15 = 1'b0;
        repeat (20) @(posedge clk);
        total++;
        if (acc1.size() < 40 || acc15.size() < 10) begin
            bad++;
            $display("FAIL sweep_count got=%0d,%0d exp>=40,10", acc1.size(), acc15.size());
        end
        total++;
        if (acc1.size() == 0 || acc1[0] != 0) begin
            bad++; $display("FAIL sweep_first got=%0d exp=0", acc1.size() ? acc1[0] : -1);
        end
        for (int i = 0; i < rsp1.size() && i < acc1.size(); i++) begin
            total++;
            if (rsp1[i] - acc1[i] != 1) begin
                bad++; $display("FAIL lat1 got=%0d exp=1", rsp1[i] - acc1[i]);
            end
        end
        for (int i = 0; i + 1 < acc1.size(); i++) begin
            total++;
            if (acc1[i+1] - acc1[i] != 3) begin
                bad++; $display("FAIL space1 got=%0d exp=3", acc1[i+1] - acc1[i]);
            end
        end
        for (int i = 0; i < rsp15.size() && i < acc15.size(); i++) begin
            total++;
            if (rsp15[i] - acc15[i] != 15) begin
                bad++; $display("FAIL lat15 got=%0d exp=15", rsp15[i] - acc15[i]);
            end
        end
        for (int i = 0; i + 1 < acc15.size(); i++) begin
            total++;
            if (acc15[i+1] - acc15[i] != 17) begin
                bad++; $display("FAIL space15 got=%0d exp=17", acc15[i+1] - acc15[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_store_load();
        test_backpressure();
        test_out_of_range();
        test_reset_mid();
        test_ignored_inputs();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 512, number of 32-bit data words stored.
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to response; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 req_valid  input  1  the MEM stage presents a request.
REQ-006 req_ready  output  1  the block accepts a request this cycle.
REQ-007 req_write  input  1  1 = store (memWrite), 0 = load (memRead).
REQ-008 req_addr  input  32  word address (word-indexed, same as pc increment by 1).
REQ-009 req_wdata  input  32  store data (regToMem value).
REQ-010 resp_valid  output  1  a response is presented; held until accepted.
REQ-011 resp_ready  input  1  the MEM stage accepts the response.
REQ-012 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 resp_err  output  1  the address was out of range (req_addr >= DEPTH).
REQ-014 stall  output  1  high whenever state != IDLE; freezes the pipeline registers.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 Acceptance SHALL occur on a posedge where req_valid=1 and req_ready=1.
- Captures write, addr, wdata.
- Loads counter with LATENCY-1.
- Moves IDLE->WAIT.
REQ-018 In WAIT, if counter=0 the FSM SHALL move to RESP; otherwise it SHALL decrement the counter.
- Consequence: RESP is entered exactly LATENCY posedges after acceptance.
REQ-019 On the WAIT->RESP edge, for in-range addresses:
- A store SHALL write wdata to mem[addr].
- A load SHALL register mem[addr] into resp_rdata.
REQ-020 For out-of-range addresses:
- No array write SHALL occur.
- resp_err SHALL be 1 and resp_rdata SHALL be 0.
- The address compare SHALL use the full 32 bits, with no truncation or wrap.
REQ-021 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err SHALL be stable until resp_ready=1.
- On that edge the FSM SHALL return to IDLE and clear resp_valid, resp_rdata and resp_err.
REQ-022 A new request SHALL NOT be accepted on the same edge a response completes.
- req_ready becomes 1 the cycle after.
- Minimum request spacing is LATENCY+2 cycles.
REQ-023 req_valid, req_write, req_addr and req_wdata SHALL be ignored outside IDLE.
REQ-024 A load from an address written by the immediately preceding store SHALL return the new data.
REQ-025 The block SHALL be word-only: no byte enables, no unaligned handling.

Reset
REQ-026 When rst=1, the block SHALL asynchronously force:
- state=IDLE and counter=0;
- req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, stall=0.
REQ-027 Memory array contents SHALL NOT be reset.
REQ-028 Reset asserted in WAIT SHALL discard the pending request.
- A store that has not yet reached the WAIT->RESP edge SHALL leave the array unchanged.
REQ-029 Reset asserted in RESP SHALL drop the response.
- A store already committed SHALL remain written.
REQ-030 After rst deasserts, the first request SHALL be accepted on the first posedge with req_valid=1.

Verification
REQ-031 Store then load (LATENCY=2): store addr=5, wdata=32'hDEADBEEF, resp_ready=1.
- Response: resp_valid at 2 cycles, resp_rdata=0, resp_err=0.
- Then load addr=5 -> resp_rdata=32'hDEADBEEF 2 cycles after acceptance.
REQ-032 Backpressure: load addr=7 with resp_ready=0 for 4 cycles.
- resp_valid, resp_rdata and stall SHALL hold for all 4 cycles.
- Release resp_ready -> IDLE next edge and req_ready=1.
REQ-033 Out of range: store addr=512 wdata=1 -> resp_err=1 and no array change.
- Load addr=32'hFFFF_FFFF -> resp_err=1 and resp_rdata=0.
- Load addr=0 -> unchanged prior value.
REQ-034 Reset mid-op: store addr=9 wdata=32'h1234, assert rst during WAIT.
- All outputs SHALL reach reset values immediately.
- Later load addr=9 returns the pre-store value.
REQ-035 Latency sweep: LATENCY=1 and LATENCY=15 with back-to-back req_valid.
- resp_valid SHALL appear exactly LATENCY cycles after acceptance.
- Acceptances SHALL be spaced LATENCY+2 cycles with resp_ready tied high.
REQ-036 Ignored inputs: toggle req_addr/req_wdata during WAIT.
- The response SHALL reflect the captured values only.
